control_registro_datos: RTL and testbench

- Controller and arbiter for the two-entry 32-bit data register bank that sits between the soft processor, the UART receiver and the UART transmitter.
- Shares the bank's two write ports between processor accesses and received UART bytes.
- Exposes a 4-address processor map.
- On command, sequences a 4-byte UART transmission of register 0, least significant byte first, from a snapshot of that register.

---
 rtl/control_registro_datos.sv | 143 ++++++++++++++
 tb/tb_control_registro_datos.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_registro_datos.sv
// Arbitrates the two-port data register bank between CPU and UART RX, and
// sequences an NBYTES LSB-first UART transmission from a snapshot of reg0.
module control_registro_datos #(
  parameter int NBYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rf_wr1,
  output logic [31:0] rf_in1,
  output logic        rf_addr1,
  output logic        rf_wr2,
  output logic [31:0] rf_in2,
  output logic        rf_addr2,
  input  logic [31:0] rf_out,
  input  logic [31:0] rf_out_d0,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        tx_done,
  output logic        rx_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_SEND, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_rvalid, r_rx_pending, r_overrun;
  logic [31:0] r_rdata, r_shift;
  logic [1:0]  r_cnt;

  logic        w_collide, w_acc, w_wr, w_rd, w_ctrl_wr, w_start;
  logic        w_ovr_set, w_ovr_clr, w_hs, w_last;
  logic [31:0] w_rd_mux;

  // A CPU write to reg1 would collide with the RX byte on the same entry; RX wins.
  assign w_collide = cpu_req & cpu_we & (cpu_addr == 2'd1) & rx_valid;
  assign cpu_ready = cpu_req & ~w_collide;
  assign w_acc     = cpu_req & cpu_ready;
  assign w_wr      = w_acc & cpu_we;
  assign w_rd      = w_acc & ~cpu_we;
  assign w_ctrl_wr = w_wr & (cpu_addr == 2'd2);
  assign w_start   = w_ctrl_wr & cpu_wdata[0] & (r_state == S_IDLE);
  assign w_ovr_set = rx_valid & r_rx_pending;
  assign w_ovr_clr = w_ctrl_wr & cpu_wdata[1];
  assign w_hs      = tx_valid & tx_ready;
  assign w_last    = (r_cnt == 2'(NBYTES - 1));

  assign rf_wr1   = w_wr & ~cpu_addr[1];
  assign rf_addr1 = cpu_addr[0];
  assign rf_in1   = rf_wr1 ? cpu_wdata : 32'd0;
  assign rf_wr2   = rx_valid;
  assign rf_addr2 = rx_valid;
  assign rf_in2   = rx_valid ? {24'd0, rx_data} : 32'd0;

  assign cpu_rvalid = r_rvalid;
  assign cpu_rdata  = r_rdata;
  assign rx_overrun = r_overrun;

  always_comb begin
    w_rd_mux = 32'd0;
    case (cpu_addr)
      2'd0, 2'd1: w_rd_mux = rf_out;
      2'd2:       w_rd_mux = {30'd0, r_overrun, busy};
      default:    w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid     <= 1'b0;
      r_rdata      <= 32'd0;
      r_rx_pending <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd)
        r_rdata <= w_rd_mux;
      // A fresh byte keeps pending set even if reg1 is read in the same cycle.
      if (rx_valid)
        r_rx_pending <= 1'b1;
      else if (w_rd && cpu_addr == 2'd1)
        r_rx_pending <= 1'b0;
      if (w_ovr_set)
        r_overrun <= 1'b1;
      else if (w_ovr_clr)
        r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= 32'd0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_SNAP) begin
        r_shift <= rf_out_d0;
        r_cnt   <= 2'd0;
      end else if (r_state == S_SEND && w_hs) begin
        r_shift <= r_shift >> 8;
        r_cnt   <= r_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    tx_done  = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_SNAP;
      S_SNAP: begin
        busy   = 1'b1;
        w_next = S_SEND;
      end
      S_SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = r_shift[7:0];
        if (w_hs && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        tx_done = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_registro_datos.sv
// Directed bench for control_registro_datos with a behavioural register bank.
module tb_control_registro_datos;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rf_wr1, rf_addr1, rf_wr2, rf_addr2;
  logic [31:0] rf_in1, rf_in2, rf_out, rf_out_d0;
  logic        tx_valid, tx_ready, busy, tx_done, rx_overrun;
  logic [7:0]  tx_data;

  int n_pass = 0;
  int n_total = 0;

  // Bank model: reg0 is a full word, reg1 holds a UART byte (bits [7:0] only).
  logic [31:0] bank0 = 32'd0;
  logic [7:0]  bank1 = 8'd0;

  always @(posedge clk) begin
    if (rf_wr1) begin
      if (rf_addr1) bank1 <= rf_in1[7:0];
      else          bank0 <= rf_in1;
    end
    if (rf_wr2 && rf_addr2) bank1 <= rf_in2[7:0];
  end

  assign rf_out    = rf_addr1 ? {24'd0, bank1} : bank0;
  assign rf_out_d0 = bank0;

  always #5 clk = ~clk;

  control_registro_datos #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rf_wr1(rf_wr1), .rf_in1(rf_in1), .rf_addr1(rf_addr1),
    .rf_wr2(rf_wr2), .rf_in2(rf_in2), .rf_addr2(rf_addr2),
    .rf_out(rf_out), .rf_out_d0(rf_out_d0),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .rx_overrun(rx_overrun)
  );

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic vld, output logic [31:0] data);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    vld  = cpu_rvalid;
    data = cpu_rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 2'd0; cpu_wdata = 32'd0;
    rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if ({cpu_ready, cpu_rvalid, tx_valid, busy, tx_done, rx_overrun, rf_wr1, rf_wr2} !== 8'd0)
      $display("FAIL reset_flags: got %b required 00000000",
               {cpu_ready, cpu_rvalid, tx_valid, busy, tx_done, rx_overrun, rf_wr1, rf_wr2});
    else n_pass++;
    n_total++;
    if (cpu_rdata !== 32'd0 || tx_data !== 8'd0)
      $display("FAIL reset_data: rdata %h tx_data %h required 0", cpu_rdata, tx_data);
    else n_pass++;
  endtask

  task automatic test_tx_basic;
    logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    tx_ready = 1'b1;
    cpu_write(2'd0, 32'hA1B2C3D4);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd2; cpu_wdata = 32'h1;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b1 || tx_valid !== 1'b0)
      $display("FAIL tx_snap: busy %b tx_valid %b required 1 0", busy, tx_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_total++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i])
        $display("FAIL tx_byte%0d: valid %b data %h required 1 %h", i, tx_valid, tx_data, exp[i]);
      else n_pass++;
    end
    @(negedge clk); #1;
    n_total++;
    if (tx_done !== 1'b1 || tx_valid !== 1'b0)
      $display("FAIL tx_done_pulse: done %b valid %b required 1 0", tx_done, tx_valid);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (tx_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL tx_idle: done %b busy %b required 0 0", tx_done, busy);
    else n_pass++;
  endtask

  task automatic test_tx_stall;
    logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    logic [7:0] got [8];
    logic [7:0] prev;
    logic       stalled = 1'b0;
    int nb = 0;
    int ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tx_ready = (c % 3 == 2);
      if (c == 0 || c == 5) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd2; cpu_wdata = 32'h1;
      end else begin
        cpu_req = 1'b0; cpu_we = 1'b0;
      end
      #1;
      if (c == 5) begin
        n_total++;
        if (cpu_ready !== 1'b1 || busy !== 1'b1)
          $display("FAIL stall_restart_ready: ready %b busy %b required 1 1", cpu_ready, busy);
        else n_pass++;
      end
      if (tx_valid) begin
        if (stalled) begin
          n_total++;
          if (tx_data !== prev)
            $display("FAIL stall_stable: data %h required %h", tx_data, prev);
          else n_pass++;
        end
        if (tx_ready) begin
          if (nb < 8) got[nb] = tx_data;
          nb++;
          stalled = 1'b0;
        end else begin
          prev = tx_data;
          stalled = 1'b1;
        end
      end
      if (tx_done) ndone++;
    end
    cpu_req = 1'b0; cpu_we = 1'b0; tx_ready = 1'b1;
    n_total++;
    if (nb !== 4 || ndone !== 1)
      $display("FAIL stall_count: bytes %0d dones %0d required 4 1", nb, ndone);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (got[i] !== exp[i])
        $display("FAIL stall_byte%0d: got %h required %h", i, got[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rx;
    logic        v;
    logic [31:0] d;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h5A;
    #1;
    n_total++;
    if (rf_wr2 !== 1'b1 || rf_addr2 !== 1'b1 || rf_in2 !== 32'h5A)
      $display("FAIL rx_port2: wr %b addr %b in %h required 1 1 0000005a", rf_wr2, rf_addr2, rf_in2);
    else n_pass++;
    @(negedge clk);
    rx_valid = 1'b0;
    do_read(2'd1, v, d);
    n_total++;
    if (v !== 1'b1 || d !== 32'h5A)
      $display("FAIL rx_read1: valid %b data %h required 1 0000005a", v, d);
    else n_pass++;
    do_read(2'd2, v, d);
    n_total++;
    if (v !== 1'b1 || d !== 32'h0)
      $display("FAIL rx_status: valid %b data %h required 1 00000000", v, d);
    else n_pass++;
  endtask

  task automatic test_overrun;
    logic        v;
    logic [31:0] d;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h11;
    @(negedge clk);
    rx_data = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    do_read(2'd2, v, d);
    n_total++;
    if (d !== 32'h2) $display("FAIL ovr_status_set: got %h required 00000002", d);
    else n_pass++;
    do_read(2'd1, v, d);
    n_total++;
    if (d !== 32'h22) $display("FAIL ovr_read1: got %h required 00000022", d);
    else n_pass++;
    cpu_write(2'd2, 32'h2);
    do_read(2'd2, v, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL ovr_status_clr: got %h required 00000000", d);
    else n_pass++;
  endtask

  task automatic test_collision;
    logic        v;
    logic [31:0] d;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd1; cpu_wdata = 32'hFFFF0033;
    rx_valid = 1'b1; rx_data = 8'h44;
    #1;
    n_total++;
    if (cpu_ready !== 1'b0 || rf_wr1 !== 1'b0 || rf_wr2 !== 1'b1)
      $display("FAIL coll_stall: ready %b wr1 %b wr2 %b required 0 0 1", cpu_ready, rf_wr1, rf_wr2);
    else n_pass++;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    n_total++;
    if (cpu_ready !== 1'b1 || rf_wr1 !== 1'b1 || rf_addr1 !== 1'b1 || bank1 !== 8'h44)
      $display("FAIL coll_retry: ready %b wr1 %b addr1 %b bank1 %h required 1 1 1 44",
               cpu_ready, rf_wr1, rf_addr1, bank1);
    else n_pass++;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    do_read(2'd1, v, d);
    n_total++;
    if (v !== 1'b1 || d !== 32'h33)
      $display("FAIL coll_read1: valid %b data %h required 1 00000033", v, d);
    else n_pass++;
    // Reserved address: write accepted and ignored, read returns zero.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd3; cpu_wdata = 32'hFFFFFFFF;
    #1;
    n_total++;
    if (cpu_ready !== 1'b1 || rf_wr1 !== 1'b0 || busy !== 1'b0)
      $display("FAIL addr3_write: ready %b wr1 %b busy %b required 1 0 0", cpu_ready, rf_wr1, busy);
    else n_pass++;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    do_read(2'd3, v, d);
    n_total++;
    if (v !== 1'b1 || d !== 32'h0)
      $display("FAIL addr3_read: valid %b data %h required 1 00000000", v, d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_send;
    logic [7:0] exp [4] = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
    logic [7:0] got [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int nb = 0;
    tx_ready = 1'b1;
    cpu_write(2'd0, 32'h0A0B0C0D);
    cpu_write(2'd2, 32'h1);
    // Now in SNAP; the next two cycles hand over bytes 0 and 1.
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_abort: valid %b busy %b required 0 0", tx_valid, busy);
    else n_pass++;
    rst = 1'b0;
    cpu_write(2'd2, 32'h1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (tx_valid && tx_ready) begin
        if (nb < 4) got[nb] = tx_data;
        nb++;
      end
    end
    n_total++;
    if (nb !== 4) $display("FAIL rst_resend_count: got %0d required 4", nb);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (got[i] !== exp[i])
        $display("FAIL rst_resend_byte%0d: got %h required %h", i, got[i], exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_tx_basic;
    test_tx_stall;
    test_rx;
    test_overrun;
    test_collision;
    test_reset_mid_send;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

endmodule
